// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared GPIO definitions: register map and alert receiver types
// Purpose : constants and types shared by the GPIO block and its alert receiver.
// Ports   : none (package).
package gpio_pkg;

  // Register map
  localparam int unsigned GPIO_REG_AW            = 6;
  localparam logic [5:0]  GPIO_DATA_IN_OFFSET    = 6'h00;
  localparam logic [5:0]  GPIO_DIRECT_OUT_OFFSET = 6'h04;
  localparam logic [5:0]  GPIO_DIRECT_OE_OFFSET  = 6'h08;
  localparam logic [5:0]  GPIO_INTR_STATE_OFFSET = 6'h0c;

  // Alert receiver handshake states
  typedef enum logic [1:0] {
    AlertIdle      = 2'd0,
    AlertHsAckWait = 2'd1,
    AlertPause0    = 2'd2,
    AlertPause1    = 2'd3
  } alert_rx_state_e;

  // Idle levels of the differential pairs.
  // alert_tx = {alert_p, alert_n}; alert_rx = {ping_p, ping_n, ack_p, ack_n}
  localparam logic [1:0] ALERT_TX_RST = 2'b01;
  localparam logic [3:0] ALERT_RX_RST = 4'b0101;

endpackage

// File: rtl/gpio_diff_sync.sv
// rtl/gpio_diff_sync.sv - two-flop synchronizer for a differential pair
// Purpose : brings an asynchronous differential pair into the clk_i domain.
// Ports   : clk_i  - clock
//           rst_ni - asynchronous active-low reset (flops go to the idle pair level)
//           diff_i - {p, n} asynchronous input
//           diff_o - {p, n} synchronized output, two cycles of latency
module gpio_diff_sync
  import gpio_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] diff_i,
  output logic [1:0] diff_o
);

  logic [1:0] stage1_q;
  logic [1:0] stage2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= ALERT_TX_RST;
      stage2_q <= ALERT_TX_RST;
    end else begin
      stage1_q <= diff_i;
      stage2_q <= stage1_q;
    end
  end

  assign diff_o = stage2_q;

endmodule

// File: rtl/gpio_alert_receiver.sv
// rtl/gpio_alert_receiver.sv - differential alert receiver with ping support
// Purpose : receives a differential alert, acknowledges it with a four-phase
//           handshake, distinguishes ping answers from genuine alerts and flags
//           non-differential (integrity) faults.
// Ports   : clk_i        - clock
//           rst_ni       - asynchronous active-low reset
//           alert_tx_i   - {alert_p, alert_n} from the sender
//           alert_rx_o   - {ping_p, ping_n, ack_p, ack_n} to the sender
//           ping_req_i   - single-cycle ping request
//           ping_ok_o    - one-cycle pulse when the sender answers a ping
//           alert_o      - one-cycle pulse per genuine alert
//           integ_fail_o - high while the sampled alert pair is non-differential
module gpio_alert_receiver
  import gpio_pkg::*;
#(
  parameter bit AsyncOn = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] alert_tx_i,
  output logic [3:0] alert_rx_o,
  input  logic       ping_req_i,
  output logic       ping_ok_o,
  output logic       alert_o,
  output logic       integ_fail_o
);

  logic [1:0] alert_s;

  if (AsyncOn) begin : gen_sync
    gpio_diff_sync u_diff_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .diff_i (alert_tx_i),
      .diff_o (alert_s)
    );
  end else begin : gen_no_sync
    assign alert_s = alert_tx_i;
  end

  logic ap, an;
  logic integ_fail;
  logic alert_set, alert_clr;

  assign ap         = alert_s[1];
  assign an         = alert_s[0];
  assign integ_fail = (ap == an);
  assign alert_set  = ap & ~an;
  assign alert_clr  = ~ap & an;

  alert_rx_state_e state_q, state_d;
  logic ping_pend_q, ping_pend_d;
  logic ping_p_q, ping_p_d;
  logic ack_p_q, ack_p_d;
  logic alert_q, alert_d;
  logic ping_ok_q, ping_ok_d;

  always_comb begin
    state_d     = state_q;
    ping_pend_d = ping_pend_q;
    ping_p_d    = ping_p_q;
    ack_p_d     = 1'b0;
    alert_d     = 1'b0;
    ping_ok_d   = 1'b0;

    // A broken pair aborts any handshake and suppresses all reporting.
    if (integ_fail) begin
      state_d = AlertIdle;
    end else begin
      unique case (state_q)
        AlertIdle: begin
          if (alert_set) begin
            state_d = AlertHsAckWait;
            if (ping_pend_q) begin
              ping_ok_d   = 1'b1;
              ping_pend_d = 1'b0;
            end else begin
              alert_d = 1'b1;
            end
          end
        end
        AlertHsAckWait: begin
          // Ack rises one cycle after entering this state and drops in the
          // same edge that leaves it.
          if (alert_clr) state_d = AlertPause0;
          else           ack_p_d = 1'b1;
        end
        AlertPause0: state_d = AlertPause1;
        AlertPause1: state_d = AlertIdle;
        default:     state_d = AlertIdle;
      endcase
    end

    // Pings are launched in any state. An alert detected in Idle in the same
    // cycle was evaluated against the old flag, so it is reported as an alert.
    if (ping_req_i && !ping_pend_q) begin
      ping_pend_d = 1'b1;
      ping_p_d    = ~ping_p_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= AlertIdle;
      ping_pend_q <= 1'b0;
      ping_p_q    <= ALERT_RX_RST[3];
      ack_p_q     <= ALERT_RX_RST[1];
      alert_q     <= 1'b0;
      ping_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ping_pend_q <= ping_pend_d;
      ping_p_q    <= ping_p_d;
      ack_p_q     <= ack_p_d;
      alert_q     <= alert_d;
      ping_ok_q   <= ping_ok_d;
    end
  end

  assign alert_rx_o   = {ping_p_q, ~ping_p_q, ack_p_q, ~ack_p_q};
  assign alert_o      = alert_q;
  assign ping_ok_o    = ping_ok_q;
  // Gated so an unsynchronized build still reads 0 while held in reset.
  assign integ_fail_o = integ_fail & rst_ni;

endmodule

// File: doc/gpio_alert_receiver.md
GPIO_ALERT_RECEIVER -- requirements
Module: gpio_alert_receiver

Interface
REQ-001 SHALL have parameter AsyncOn, default 1'b1: 1 = alert_tx_i passes through a 2-flop synchronizer; 0 = it is sampled directly.
REQ-002 SHALL have port clk_i, input, 1: the single clock.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port alert_tx_i, input, 2: {alert_p, alert_n}, the differential alert from the sender.
REQ-005 SHALL have port alert_rx_o, output, 4: {ping_p, ping_n, ack_p, ack_n}, the differential ping and ack to the sender.
REQ-006 SHALL have port ping_req_i, input, 1: single-cycle ping request pulse.
REQ-007 SHALL have port ping_ok_o, output, 1: one-cycle pulse when the sender answers a ping.
REQ-008 SHALL have port alert_o, output, 1: one-cycle pulse per genuine (non-ping) alert.
REQ-009 SHALL have port integ_fail_o, output, 1: high in every cycle the sampled alert pair is non-differential.

Function
REQ-010 SHALL define the sampled pair (ap, an) as the synchronized alert_tx_i when AsyncOn=1 (2 cycles latency), else alert_tx_i itself.
REQ-011 SHALL treat ap==an as an integrity fault: integ_fail_o=1 in that cycle (combinational from the sample), FSM forced to Idle, ack_p=0/ack_n=1 next cycle, no alert_o or ping_ok_o.
REQ-012 SHALL implement the FSM states Idle, HsAckWait, Pause0 and Pause1.
REQ-013 Idle, ap=1/an=0: SHALL go to HsAckWait. With a ping outstanding, SHALL pulse ping_ok_o next cycle and clear the outstanding flag. Otherwise SHALL pulse alert_o next cycle.
REQ-014 HsAckWait: SHALL drive ack_p=1/ack_n=0 (registered). On ap=0/an=1, SHALL go to Pause0 and drive ack_p=0/ack_n=1.
REQ-015 Pause0 SHALL advance to Pause1, and Pause1 SHALL advance to Idle. Alerts seen in Pause0/Pause1 SHALL be ignored; they are handled on return to Idle if still asserted.
REQ-016 Ping: a ping_req_i pulse with no ping outstanding SHALL set the outstanding flag and toggle ping_p/ping_n (kept complementary) on the next edge, in any FSM state. A ping_req_i pulse while one is outstanding SHALL be ignored.
REQ-017 A ping_req_i and an alert detected in Idle in the same cycle: the alert SHALL be reported as alert_o (the ping is not yet sent), and the ping SHALL be sent and left outstanding.
REQ-018 SHALL never assert alert_o and ping_ok_o in the same cycle.
REQ-019 SHALL allow back-to-back handshakes: the minimum alert-to-alert period is 4 cycles plus sender latency.

Reset
REQ-020 On rst_ni low (asynchronous), the block SHALL enter Idle, clear the outstanding flag, and clear the synchronizer flops to ap=0/an=1.
REQ-021 During reset, outputs SHALL be: alert_rx_o={ping_p=0, ping_n=1, ack_p=0, ack_n=1}; alert_o=0; ping_ok_o=0; integ_fail_o=0.
REQ-022 Reset asserted mid-handshake SHALL abort it with no pulse generated; a still-asserted alert after release SHALL be reported once as a fresh alert.

Structure
REQ-023 The FSM state enum (2-bit) and the reset encodings of alert_rx_o SHALL live in the shared gpio package, alongside the existing register definitions.
REQ-024 The 2-flop differential synchronizer SHALL be one sub-module, gpio_diff_sync, instantiated only when AsyncOn=1.
REQ-025 The block SHALL be instantiated once per NUM_ALERTS bit at the system alert handler.

Verification
REQ-026 AsyncOn=1; drive alert_tx_i=2'b10 at cycle 0 and hold -> alert_o pulses once at cycle 3, ack_p=1 from cycle 4; release to 2'b01 -> ack_p=0 three cycles later, Idle two cycles after that.
REQ-027 ping_req_i pulse -> ping_p toggles 0->1 next cycle, ping_n 1->0; sender answers with a 2'b10 handshake -> ping_ok_o pulses once, alert_o stays 0.
REQ-028 alert_tx_i=2'b11 for 5 cycles during HsAckWait -> integ_fail_o high for 5 (synced) cycles, ack_p=0, FSM Idle, no alert_o.
REQ-029 ping_req_i and alert detection coincide in Idle -> alert_o=1, ping_ok_o=0; a second 2'b10 handshake -> ping_ok_o=1.
REQ-030 rst_ni low while in HsAckWait with alert held at 2'b10 -> alert_rx_o=4'b0101 immediately; after release, exactly one alert_o pulse.
